// File: rtl/ethernet_frame_parser.sv
// Ethernet receive front end: preamble/SFD lock, header capture, frame classification and body streaming.
// Optional build macro ETH_MAC_FILTER_EN drops frames not addressed to LOCAL_MAC or broadcast.
module ethernet_frame_parser #(
  parameter int PREAMBLE_MIN  = 7,
  parameter int MAX_FRAME_LEN = 1518
`ifdef ETH_MAC_FILTER_EN
  ,
  parameter logic [47:0] LOCAL_MAC = 48'h211abcdef112
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_ethertype,
  output logic        o_hdr_valid,
  output logic [1:0]  o_frame_type,
  output logic [7:0]  o_payload_data,
  output logic        o_payload_valid,
  output logic        o_payload_last,
  output logic        o_frame_done,
  output logic        o_frame_error
);

  localparam logic [3:0]  PRE_MIN = 4'(PREAMBLE_MIN);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        armed_q, armed_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [15:0] ethertype_q, ethertype_d;
  logic [7:0]  proto_q, proto_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [1:0]  frame_type_q, frame_type_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  pay_data_q, pay_data_d;
  logic        pay_valid_q, pay_valid_d;
  logic        pay_last_q, pay_last_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  frame_class;

`ifdef ETH_MAC_FILTER_EN
  logic [15:0] filt_cnt_q, filt_cnt_d;
  logic [47:0] dst_full;
  logic        dst_match;

  // The sixth destination byte is still on i_data, so compare against the would-be register value.
  assign dst_full  = {dst_mac_q[39:0], i_data};
  assign dst_match = (dst_full == LOCAL_MAC) || (dst_full == 48'hffffffffffff);
`endif

  always_comb begin
    frame_class = 2'b00;
    if (ethertype_q == 16'h0806) begin
      frame_class = 2'b01;
    end else if (ethertype_q == 16'h0800) begin
      if (proto_q == 8'h01) begin
        frame_class = 2'b10;
      end else if (proto_q == 8'h11) begin
        frame_class = 2'b11;
      end
    end
  end

  // armed_q stays low after reset until i_valid has been seen low, so a frame cut by reset is dropped whole.
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    armed_d      = armed_q | ~i_valid;
    dst_mac_d    = dst_mac_q;
    src_mac_d    = src_mac_q;
    ethertype_d  = ethertype_q;
    proto_d      = proto_q;
    hdr_valid_d  = 1'b0;
    frame_type_d = frame_type_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    pay_data_d   = pay_data_q;
    pay_valid_d  = 1'b0;
    pay_last_d   = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
`ifdef ETH_MAC_FILTER_EN
    filt_cnt_d   = filt_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (armed_q && (i_data == 8'h55)) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (!i_valid) begin
          state_d = S_IDLE;
        end else if (i_data == 8'h55) begin
          if (pre_cnt_q != 4'hf) begin
            pre_cnt_d = pre_cnt_q + 4'd1;
          end
        end else if ((i_data == 8'hd5) && (pre_cnt_q >= PRE_MIN)) begin
          state_d      = S_HEADER;
          byte_cnt_d   = 11'd0;
          frame_type_d = 2'b00;
          proto_d      = 8'h00;
        end else begin
          state_d = S_DROP;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end

      S_HEADER: begin
        if (!i_valid) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          if (byte_cnt_q < 11'd6) begin
            dst_mac_d = {dst_mac_q[39:0], i_data};
          end else if (byte_cnt_q < 11'd12) begin
            src_mac_d = {src_mac_q[39:0], i_data};
          end else begin
            ethertype_d = {ethertype_q[7:0], i_data};
          end
          if (byte_cnt_q == 11'd13) begin
            state_d      = S_PAYLOAD;
            hdr_valid_d  = 1'b1;
            hold_valid_d = 1'b0;
          end
`ifdef ETH_MAC_FILTER_EN
          if ((byte_cnt_q == 11'd5) && !dst_match) begin
            state_d    = S_DROP;
            filt_cnt_d = filt_cnt_q + 16'd1;
          end
`endif
        end
      end

      // Each body byte waits in hold_q until we know whether it is the last one.
      S_PAYLOAD: begin
        if (!i_valid) begin
          state_d      = S_IDLE;
          done_d       = 1'b1;
          frame_type_d = frame_class;
          hold_valid_d = 1'b0;
          if (hold_valid_q) begin
            pay_data_d  = hold_q;
            pay_valid_d = 1'b1;
            pay_last_d  = 1'b1;
          end
        end else if (byte_cnt_q == MAX_LEN) begin
          state_d      = S_DROP;
          done_d       = 1'b1;
          error_d      = 1'b1;
          hold_valid_d = 1'b0;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          if (byte_cnt_q == 11'd23) begin
            proto_d = i_data;
          end
          if (hold_valid_q) begin
            pay_data_d  = hold_q;
            pay_valid_d = 1'b1;
          end
          hold_d       = i_data;
          hold_valid_d = 1'b1;
        end
      end

      S_DROP: begin
        if (!i_valid) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      armed_q      <= 1'b0;
      dst_mac_q    <= '0;
      src_mac_q    <= '0;
      ethertype_q  <= '0;
      proto_q      <= '0;
      hdr_valid_q  <= 1'b0;
      frame_type_q <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      pay_data_q   <= '0;
      pay_valid_q  <= 1'b0;
      pay_last_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef ETH_MAC_FILTER_EN
      filt_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      armed_q      <= armed_d;
      dst_mac_q    <= dst_mac_d;
      src_mac_q    <= src_mac_d;
      ethertype_q  <= ethertype_d;
      proto_q      <= proto_d;
      hdr_valid_q  <= hdr_valid_d;
      frame_type_q <= frame_type_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      pay_data_q   <= pay_data_d;
      pay_valid_q  <= pay_valid_d;
      pay_last_q   <= pay_last_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef ETH_MAC_FILTER_EN
      filt_cnt_q   <= filt_cnt_d;
`endif
    end
  end

  assign o_dst_mac       = dst_mac_q;
  assign o_src_mac       = src_mac_q;
  assign o_ethertype     = ethertype_q;
  assign o_hdr_valid     = hdr_valid_q;
  assign o_frame_type    = frame_type_q;
  assign o_payload_data  = pay_data_q;
  assign o_payload_valid = pay_valid_q;
  assign o_payload_last  = pay_last_q;
  assign o_frame_done    = done_q;
  assign o_frame_error   = error_q;

endmodule

// File: tb/tb_ethernet_frame_parser.sv
// Directed bench for ethernet_frame_parser: a negedge monitor records output events,
// and each test task compares them with hand-computed expectations.
module tb_ethernet_frame_parser;

  localparam logic [47:0] LOCAL = 48'h211abcdef112;
  localparam logic [47:0] SRC   = 48'h40b0769ea12e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic [47:0] o_dst_mac, o_src_mac;
  logic [15:0] o_ethertype;
  logic        o_hdr_valid, o_payload_valid, o_payload_last, o_frame_done, o_frame_error;
  logic [1:0]  o_frame_type;
  logic [7:0]  o_payload_data;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  logic [7:0] body_q[$];

  logic [7:0] pay_q[$];
  int         last_pos_q[$];
  logic       done_err_q[$];
  logic [1:0] done_ft_q[$];
  int         hdr_cnt = 0;

  always #5 clk = ~clk;

  ethernet_frame_parser dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_data          (i_data),
    .i_valid         (i_valid),
    .o_dst_mac       (o_dst_mac),
    .o_src_mac       (o_src_mac),
    .o_ethertype     (o_ethertype),
    .o_hdr_valid     (o_hdr_valid),
    .o_frame_type    (o_frame_type),
    .o_payload_data  (o_payload_data),
    .o_payload_valid (o_payload_valid),
    .o_payload_last  (o_payload_last),
    .o_frame_done    (o_frame_done),
    .o_frame_error   (o_frame_error)
  );

  // Event recorder: only appends, so tests compare against sizes captured before their stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_hdr_valid) hdr_cnt = hdr_cnt + 1;
      if (o_payload_valid) pay_q.push_back(o_payload_data);
      if (o_payload_last) last_pos_q.push_back(pay_q.size());
      if (o_frame_done) begin
        done_err_q.push_back(o_frame_error);
        done_ft_q.push_back(o_frame_type);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic make_header(input int npre, input logic [47:0] dst, input logic [15:0] et);
    tx_q.delete();
    body_q.delete();
    repeat (npre) tx_q.push_back(8'h55);
    tx_q.push_back(8'hd5);
    for (int i = 5; i >= 0; i--) tx_q.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) tx_q.push_back(SRC[i*8 +: 8]);
    tx_q.push_back(et[15:8]);
    tx_q.push_back(et[7:0]);
  endtask

  task automatic add_body(input logic [7:0] b);
    tx_q.push_back(b);
    body_q.push_back(b);
  endtask

  task automatic make_arp(input int npre, input logic [47:0] dst);
    logic [7:0] arp [28];
    arp = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
            8'h40, 8'hb0, 8'h76, 8'h9e, 8'ha1, 8'h2e,
            8'hc0, 8'ha8, 8'h01, 8'h01,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'hc0, 8'h00, 8'h01, 8'h86};
    make_header(npre, dst, 16'h0806);
    for (int i = 0; i < 28; i++) add_body(arp[i]);
  endtask

  task automatic make_ip(input logic [7:0] proto, input logic [7:0] lastb);
    logic [7:0] h [20];
    h = '{8'h45, 8'h00, 8'h00, 8'h3c, 8'h1c, 8'h46, 8'h40, 8'h00, 8'h40, proto,
          8'hb1, 8'he6, 8'hc0, 8'ha8, 8'h00, 8'h68, 8'hc0, 8'ha8, 8'h00, 8'h01};
    make_header(7, LOCAL, 16'h0800);
    for (int i = 0; i < 20; i++) add_body(h[i]);
    for (int k = 20; k < 59; k++) add_body(8'(k));
    add_body(lastb);
  endtask

  task automatic applyStimulus(input int gap);
    foreach (tx_q[i]) begin
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_data  = tx_q[i];
    end
    repeat (gap) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_data  = 8'h00;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_dst_mac, o_src_mac, o_ethertype} !== 112'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_hdr: got %h required 0", {o_dst_mac, o_src_mac, o_ethertype});
    end
    n_cmp++;
    if ({o_hdr_valid, o_payload_valid, o_payload_last, o_frame_done, o_frame_error} !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_strobes: got %b required 00000",
               {o_hdr_valid, o_payload_valid, o_payload_last, o_frame_done, o_frame_error});
    end
    n_cmp++;
    if ({o_frame_type, o_payload_data} !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_type_data: got %h required 0", {o_frame_type, o_payload_data});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_arp;
    int bp, bd, bh, bl, n, bad;
    bp = pay_q.size(); bd = done_err_q.size(); bh = hdr_cnt; bl = last_pos_q.size();
    make_arp(7, LOCAL);
    applyStimulus(4);
    n = pay_q.size() - bp;
    n_cmp++;
    if (hdr_cnt - bh != 1) begin
      n_fail++; $display("[TB] FAIL arp_hdr_valid: got %0d pulses required 1", hdr_cnt - bh);
    end
    n_cmp++;
    if (n != 28) begin
      n_fail++; $display("[TB] FAIL arp_pay_count: got %0d required 28", n);
    end else begin
      n_cmp++;
      if ({pay_q[bp], pay_q[bp+1], pay_q[bp+2], pay_q[bp+3]} !== 32'h00010800) begin
        n_fail++; $display("[TB] FAIL arp_first4: got %h required 00010800",
                           {pay_q[bp], pay_q[bp+1], pay_q[bp+2], pay_q[bp+3]});
      end
      n_cmp++;
      if ({pay_q[bp+24], pay_q[bp+25], pay_q[bp+26], pay_q[bp+27]} !== 32'hc0000186) begin
        n_fail++; $display("[TB] FAIL arp_last4: got %h required c0000186",
                           {pay_q[bp+24], pay_q[bp+25], pay_q[bp+26], pay_q[bp+27]});
      end
      bad = 0;
      for (int i = 0; i < 28; i++) if (pay_q[bp+i] !== body_q[i]) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_fail++; $display("[TB] FAIL arp_body: got %0d wrong bytes required 0", bad);
      end
    end
    n_cmp++;
    if ((last_pos_q.size() - bl != 1) || (last_pos_q[bl] != bp + 28)) begin
      n_fail++; $display("[TB] FAIL arp_last: got %0d last strobes required 1 on byte 28",
                         last_pos_q.size() - bl);
    end
    n_cmp++;
    if ((done_err_q.size() - bd != 1) || (done_err_q[bd] !== 1'b0)) begin
      n_fail++; $display("[TB] FAIL arp_done: got %0d done pulses required 1 error-free",
                         done_err_q.size() - bd);
    end else begin
      n_cmp++;
      if (done_ft_q[bd] !== 2'b01) begin
        n_fail++; $display("[TB] FAIL arp_type: got %b required 01", done_ft_q[bd]);
      end
    end
    n_cmp++;
    if ({o_dst_mac, o_src_mac, o_ethertype} !== {LOCAL, SRC, 16'h0806}) begin
      n_fail++; $display("[TB] FAIL arp_fields: got %h required %h",
                         {o_dst_mac, o_src_mac, o_ethertype}, {LOCAL, SRC, 16'h0806});
    end
    n_cmp++;
    if (o_frame_type !== 2'b01) begin
      n_fail++; $display("[TB] FAIL arp_type_hold: got %b required 01", o_frame_type);
    end
  endtask

  task automatic test_back_to_back;
    int bp, bd, bh, bl, n;
    bp = pay_q.size(); bd = done_err_q.size(); bh = hdr_cnt; bl = last_pos_q.size();
    make_ip(8'h01, 8'h69);
    applyStimulus(1);
    make_ip(8'h11, 8'h78);
    applyStimulus(4);
    n = pay_q.size() - bp;
    n_cmp++;
    if (hdr_cnt - bh != 2) begin
      n_fail++; $display("[TB] FAIL b2b_hdr_valid: got %0d pulses required 2", hdr_cnt - bh);
    end
    n_cmp++;
    if (n != 120) begin
      n_fail++; $display("[TB] FAIL b2b_pay_count: got %0d required 120", n);
    end else begin
      n_cmp++;
      if ({pay_q[bp], pay_q[bp+1], pay_q[bp+2], pay_q[bp+3]} !== 32'h4500003c) begin
        n_fail++; $display("[TB] FAIL icmp_first4: got %h required 4500003c",
                           {pay_q[bp], pay_q[bp+1], pay_q[bp+2], pay_q[bp+3]});
      end
      n_cmp++;
      if ({pay_q[bp+59], pay_q[bp+60], pay_q[bp+69], pay_q[bp+119]} !== 32'h69451178) begin
        n_fail++; $display("[TB] FAIL b2b_marks: got %h required 69451178",
                           {pay_q[bp+59], pay_q[bp+60], pay_q[bp+69], pay_q[bp+119]});
      end
    end
    n_cmp++;
    if ((last_pos_q.size() - bl != 2) || (last_pos_q[bl] != bp + 60) || (last_pos_q[bl+1] != bp + 120)) begin
      n_fail++; $display("[TB] FAIL b2b_last: got %0d last strobes required 2 on bytes 60 and 120",
                         last_pos_q.size() - bl);
    end
    n_cmp++;
    if (done_err_q.size() - bd != 2) begin
      n_fail++; $display("[TB] FAIL b2b_done: got %0d done pulses required 2", done_err_q.size() - bd);
    end else begin
      n_cmp++;
      if ({done_err_q[bd], done_ft_q[bd], done_err_q[bd+1], done_ft_q[bd+1]} !== 6'b010011) begin
        n_fail++; $display("[TB] FAIL b2b_types: got %b required 010011",
                           {done_err_q[bd], done_ft_q[bd], done_err_q[bd+1], done_ft_q[bd+1]});
      end
    end
  endtask

  task automatic test_short_preamble;
    int bp, bd, bh;
    bp = pay_q.size(); bd = done_err_q.size(); bh = hdr_cnt;
    make_arp(5, LOCAL);
    applyStimulus(2);
    make_arp(7, LOCAL);
    applyStimulus(4);
    n_cmp++;
    if (done_err_q.size() - bd != 2) begin
      n_fail++; $display("[TB] FAIL shortpre_done: got %0d done pulses required 2", done_err_q.size() - bd);
    end else begin
      n_cmp++;
      if ({done_err_q[bd], done_err_q[bd+1], done_ft_q[bd+1]} !== 4'b1001) begin
        n_fail++; $display("[TB] FAIL shortpre_err: got %b required 1001",
                           {done_err_q[bd], done_err_q[bd+1], done_ft_q[bd+1]});
      end
    end
    n_cmp++;
    if ((hdr_cnt - bh != 1) || (pay_q.size() - bp != 28)) begin
      n_fail++; $display("[TB] FAIL shortpre_next: got hdr %0d pay %0d required hdr 1 pay 28",
                         hdr_cnt - bh, pay_q.size() - bp);
    end
  endtask

  task automatic test_truncated;
    int bp, bd, bh;
    bp = pay_q.size(); bd = done_err_q.size(); bh = hdr_cnt;
    make_arp(7, LOCAL);
    tx_q = tx_q[0:17];
    applyStimulus(4);
    n_cmp++;
    if ((done_err_q.size() - bd != 1) || (done_err_q[bd] !== 1'b1)) begin
      n_fail++; $display("[TB] FAIL trunc_done: got %0d done pulses required 1 with error",
                         done_err_q.size() - bd);
    end
    n_cmp++;
    if ((hdr_cnt - bh != 0) || (pay_q.size() - bp != 0)) begin
      n_fail++; $display("[TB] FAIL trunc_quiet: got hdr %0d pay %0d required 0 0",
                         hdr_cnt - bh, pay_q.size() - bp);
    end
    n_cmp++;
    if (o_dst_mac !== LOCAL) begin
      n_fail++; $display("[TB] FAIL trunc_dst: got %h required %h", o_dst_mac, LOCAL);
    end
  endtask

  task automatic test_oversize;
    int bp, bd, bl;
    bp = pay_q.size(); bd = done_err_q.size(); bl = last_pos_q.size();
    make_header(7, LOCAL, 16'h1234);
    for (int i = 0; i < 1504; i++) add_body(8'(i));
    applyStimulus(4);
    n_cmp++;
    if ((pay_q.size() - bp != 1504) || (last_pos_q.size() - bl != 1) ||
        (done_err_q.size() - bd != 1) || (done_err_q[bd] !== 1'b0) || (done_ft_q[bd] !== 2'b00)) begin
      n_fail++; $display("[TB] FAIL maxlen_ok: got pay %0d last %0d done %0d required 1504 1 1 clean other",
                         pay_q.size() - bp, last_pos_q.size() - bl, done_err_q.size() - bd);
    end
    bp = pay_q.size(); bd = done_err_q.size(); bl = last_pos_q.size();
    make_header(7, LOCAL, 16'h1234);
    for (int i = 0; i < 1505; i++) add_body(8'(i));
    applyStimulus(4);
    n_cmp++;
    if ((pay_q.size() - bp != 1503) || (last_pos_q.size() - bl != 0)) begin
      n_fail++; $display("[TB] FAIL oversize_pay: got pay %0d last %0d required 1503 0",
                         pay_q.size() - bp, last_pos_q.size() - bl);
    end
    n_cmp++;
    if ((done_err_q.size() - bd != 1) || (done_err_q[bd] !== 1'b1)) begin
      n_fail++; $display("[TB] FAIL oversize_err: got %0d done pulses required 1 with error",
                         done_err_q.size() - bd);
    end
  endtask

  task automatic test_reset_mid_payload;
    int bp, bd, bh;
    make_arp(7, LOCAL);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_data  = tx_q[i];
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_dst_mac, o_src_mac, o_ethertype} !== 112'd0) begin
      n_fail++; $display("[TB] FAIL midreset_hdr: got %h required 0", {o_dst_mac, o_src_mac, o_ethertype});
    end
    n_cmp++;
    if ({o_hdr_valid, o_payload_valid, o_payload_last, o_frame_done, o_frame_error, o_frame_type, o_payload_data} !== 15'd0) begin
      n_fail++; $display("[TB] FAIL midreset_outs: got %h required 0",
                         {o_hdr_valid, o_payload_valid, o_payload_last, o_frame_done, o_frame_error, o_frame_type, o_payload_data});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bp = pay_q.size(); bd = done_err_q.size(); bh = hdr_cnt;
    make_header(7, LOCAL, 16'h0806);
    repeat (4) tx_q.push_back(8'h5a);
    applyStimulus(4);
    n_cmp++;
    if ((done_err_q.size() - bd != 0) || (hdr_cnt - bh != 0) || (pay_q.size() - bp != 0)) begin
      n_fail++; $display("[TB] FAIL midreset_drop: got done %0d hdr %0d pay %0d required 0 0 0",
                         done_err_q.size() - bd, hdr_cnt - bh, pay_q.size() - bp);
    end
    bp = pay_q.size(); bd = done_err_q.size();
    make_arp(7, LOCAL);
    applyStimulus(4);
    n_cmp++;
    if ((done_err_q.size() - bd != 1) || (done_err_q[bd] !== 1'b0) || (done_ft_q[bd] !== 2'b01) ||
        (pay_q.size() - bp != 28)) begin
      n_fail++; $display("[TB] FAIL midreset_next: got done %0d pay %0d required 1 clean ARP with 28",
                         done_err_q.size() - bd, pay_q.size() - bp);
    end
  endtask

`ifdef ETH_MAC_FILTER_EN
  task automatic test_mac_filter;
    int bp, bd, bh;
    bp = pay_q.size(); bd = done_err_q.size(); bh = hdr_cnt;
    make_arp(7, 48'h001122334455);
    applyStimulus(4);
    n_cmp++;
    if ((done_err_q.size() - bd != 0) || (hdr_cnt - bh != 0) || (pay_q.size() - bp != 0)) begin
      n_fail++; $display("[TB] FAIL filter_drop: got done %0d hdr %0d pay %0d required 0 0 0",
                         done_err_q.size() - bd, hdr_cnt - bh, pay_q.size() - bp);
    end
    bp = pay_q.size(); bd = done_err_q.size(); bh = hdr_cnt;
    make_arp(7, 48'hffffffffffff);
    applyStimulus(4);
    n_cmp++;
    if ((done_err_q.size() - bd != 1) || (hdr_cnt - bh != 1) || (pay_q.size() - bp != 28)) begin
      n_fail++; $display("[TB] FAIL filter_bcast: got done %0d hdr %0d pay %0d required 1 1 28",
                         done_err_q.size() - bd, hdr_cnt - bh, pay_q.size() - bp);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_arp;
    test_back_to_back;
    test_short_preamble;
    test_truncated;
    test_oversize;
    test_reset_mid_payload;
`ifdef ETH_MAC_FILTER_EN
    test_mac_filter;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ethernet_frame_parser.md
Name: ethernet_frame_parser

Overview:
- Byte-stream Ethernet receive front end: consumes 8-bit words plus a valid strobe, framed as preamble, SFD, Ethernet header and body, with no FCS.
- Locks onto preamble/SFD, captures destination MAC, source MAC and EtherType, and classifies the frame as ARP, IPv4-ICMP, IPv4-UDP or other.
- Streams the body (bytes after the EtherType) to downstream ARP/ICMP/UDP handlers.
- Mirror of the fake-data transmitter used in the receiver benches: the transmitter generates this stream, this block consumes it.

Parameters:
- PREAMBLE_MIN, 7, minimum number of 0x55 bytes required before 0xD5 (SFD).
- MAX_FRAME_LEN, 1518, maximum bytes after the SFD; longer frames are errored.
- LOCAL_MAC, 48'h211abcdef112, station address; used only with ETH_MAC_FILTER_EN.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_data  in  8  received byte.
- i_valid  in  1  byte strobe; held high for the whole frame, low between frames.
- o_dst_mac  out  48  captured destination MAC.
- o_src_mac  out  48  captured source MAC.
- o_ethertype  out  16  captured EtherType.
- o_hdr_valid  out  1  1-cycle pulse when all 14 header bytes are captured.
- o_frame_type  out  2  00 other, 01 ARP, 10 ICMP, 11 UDP; held from o_frame_done until the next SFD.
- o_payload_data  out  8  body byte.
- o_payload_valid  out  1  body byte strobe.
- o_payload_last  out  1  marks the final body byte.
- o_frame_done  out  1  1-cycle end-of-frame pulse.
- o_frame_error  out  1  qualifies o_frame_done: 1 means truncated, oversize or bad SFD.

Behaviour:
- Reset, asynchronous and active-low: every output and all internal state go to 0; FSM to IDLE. Reset mid-frame abandons the frame with no done pulse. The remainder of that frame is not parsed: the FSM waits in DROP for i_valid low, then accepts the next frame.
- FSM states: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP. Decisions use only bytes with i_valid=1.
- IDLE:
  - i_valid with 0x55 -> PREAMBLE, preamble count = 1.
  - i_valid with any other byte -> DROP, no done pulse.
- PREAMBLE:
  - 0x55: count++ (count saturates at 15).
  - 0xD5 with count >= PREAMBLE_MIN -> HEADER, byte counter cleared.
  - 0xD5 with count < PREAMBLE_MIN, or any other byte -> DROP with error.
  - i_valid low -> IDLE silently.
- HEADER:
  - Bytes 0-5 shift into o_dst_mac, MSB first. Bytes 6-11 into o_src_mac. Bytes 12-13 into o_ethertype.
  - o_hdr_valid pulses in the cycle after byte 13 is accepted; FSM -> PAYLOAD.
  - i_valid low before byte 13 -> o_frame_done=1 and o_frame_error=1 next cycle, then IDLE.
- PAYLOAD:
  - Byte counter (11 bits) keeps counting. Each byte enters a 1-byte hold register.
  - On the next valid byte, the held byte is emitted with o_payload_valid=1, so latency is 2 cycles from i_data to o_payload_data.
  - When i_valid falls, the held byte is emitted with o_payload_last=1. o_frame_done pulses in that same cycle with o_frame_error=0.
  - A zero-length body gives o_frame_done only, with no payload strobe.
- Classification:
  - EtherType 0x0806 -> ARP.
  - EtherType 0x0800 with frame byte 23 (IP protocol) 0x01 -> ICMP; 0x11 -> UDP; any other value -> other.
  - Any other EtherType -> other.
  - o_frame_type updates with o_frame_done; it is cleared on SFD.
- Oversize: when the byte counter reaches MAX_FRAME_LEN with i_valid still high -> o_frame_done + o_frame_error, no o_payload_last, DROP.
- DROP: ignore bytes until i_valid=0, then IDLE. A done/error pulse issues on DROP entry only when entered from PREAMBLE (bad SFD) or by oversize.
- Back-to-back frames with a single i_valid-low cycle between them must be parsed correctly.

Optional Feature:
- Macro ETH_MAC_FILTER_EN.
- Defined: after header byte 5, o_dst_mac is compared with LOCAL_MAC and FF:FF:FF:FF:FF:FF.
  - Mismatch -> DROP with no hdr_valid, no payload and no done pulse.
  - A 1-cycle o_frame_done is not asserted; the internal filtered-frame counter (16-bit, wrapping) increments.
- Undefined: all frames are accepted and the comparator and counter are not built.

Test Plan:
- ARP frame (7x55, D5, 42 bytes; dst 211abcdef112, src 40b0769ea12e, type 0806) -> hdr_valid once; 28 payload bytes starting 00,01,08,00 and ending c0000186 with last on the 28th; done with error=0; frame_type=01.
- ICMP frame (type 0800, byte23=01, 74 bytes after SFD) -> 60 payload bytes starting 45,00,00,3c; frame_type=10; last on the final byte 69.
- UDP frame (byte23=11) sent back-to-back after ICMP with a 1-cycle gap -> both frames parsed; second gives frame_type=11, 60 payload bytes ending 78.
- Preamble of only 5x55 then D5 -> done+error, no payload; next valid ARP frame parsed normally.
- i_valid dropped after 10 header bytes -> done+error=1, hdr_valid never asserted. Separately, i_reset_n low mid-payload -> all outputs 0 immediately.
- With ETH_MAC_FILTER_EN: dst 001122334455 -> no outputs. Broadcast dst -> parsed. Dst 211abcdef112 -> parsed.
